// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// Requests use a valid/ready handshake; responses are single-cycle pulses that cannot be back-pressured.
interface instruction_fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, a two-entry output/pending buffer,
// stall hold, and full-flush redirect that drains any response still in flight.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             redirect_enable,
  input  logic [31:0]                      redirect_target,
  instruction_fetch_stage_if.master        imem,
  output logic                             if_valid,
  output logic [31:0]                      if_program_counter,
  output logic [31:0]                      if_instruction
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] pend_instr;
  logic        drop;

  logic handshake;
  logic consume;
  logic deliver;
  logic in_flight;

  // Request is masked while reset is held so every output reads 0 during reset.
  assign imem.imem_req_valid = reset && (state == S_REQ) && !pend_valid;
  assign imem.imem_req_addr  = fetch_pc;

  assign handshake = imem.imem_req_valid && imem.imem_req_ready;
  assign consume   = out_valid && !stall;
  assign deliver   = (state == S_WAIT) && imem.imem_resp_valid;
  assign in_flight = handshake || ((state != S_REQ) && !imem.imem_resp_valid);

  assign if_valid           = out_valid;
  assign if_program_counter = out_valid ? out_pc    : '0;
  assign if_instruction     = out_valid ? out_instr : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC;
      req_pc     <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      pend_instr <= '0;
      drop       <= 1'b0;
    end else if (redirect_enable) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      pend_instr <= '0;
      fetch_pc   <= redirect_target;
      // A response still owed by memory must be swallowed before the new stream starts.
      if (in_flight) begin
        state <= S_DRAIN;
        drop  <= 1'b1;
      end else begin
        state <= S_REQ;
        drop  <= 1'b0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_resp_valid) state <= S_REQ;
        end
        S_DRAIN: begin
          if (imem.imem_resp_valid && drop) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase

      if (consume) begin
        out_valid  <= pend_valid;
        out_pc     <= pend_pc;
        out_instr  <= pend_instr;
        pend_valid <= 1'b0;
        pend_pc    <= '0;
        pend_instr <= '0;
      end

      // A consumed-and-refilled cycle lets the new word go straight to the output slot.
      if (deliver) begin
        if (!out_valid || (consume && !pend_valid)) begin
          out_valid <= 1'b1;
          out_pc    <= req_pc;
          out_instr <= imem.imem_resp_data;
        end else begin
          pend_valid <= 1'b1;
          pend_pc    <= req_pc;
          pend_instr <= imem.imem_resp_data;
        end
      end
    end
  end

endmodule
